// File: rtl/sram_port_sequencer.sv
// sram_port_sequencer
//
// Shares one synchronous single-port SRAM between the CPU instruction-fetch port and its data
// port. Each instruction runs as a short sequence: fetch, wait for read data, execute (issue
// the load/store the CPU requests), and for loads one more cycle to return the data. The CPU
// is stalled on every cycle except the single commit cycle of each sequence.
//
// Ports
//   clk, rst                 single clock; synchronous active-high reset
//   instr_read, instr_addr   CPU fetch request and PC (sampled in the fetch cycle)
//   instr_out                instruction held stable for the CPU
//   data_read, data_write    CPU load request / byte strobes (looked at in the execute cycle)
//   data_addr, data_in       load/store address and store data
//   data_out                 load data to the CPU (zero except in the load-return cycle)
//   cpu_stall                high = CPU must not advance PC or write registers
//   mem_addr, mem_read,      SRAM address, read enable, byte write strobes, write data
//   mem_write, mem_di
//   mem_do                   SRAM read data, valid the cycle after mem_read is sampled
//   retired_count            instructions committed since reset (wraps)

module sram_port_sequencer #(
  parameter int unsigned    AddrWidth = 32,
  parameter int unsigned    DataWidth = 32,
  parameter logic [31:0]    NopInstr  = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 instr_read,
  input  logic [AddrWidth-1:0] instr_addr,
  output logic [DataWidth-1:0] instr_out,

  input  logic                 data_read,
  input  logic [3:0]           data_write,
  input  logic [AddrWidth-1:0] data_addr,
  input  logic [DataWidth-1:0] data_in,
  output logic [DataWidth-1:0] data_out,

  output logic                 cpu_stall,

  output logic [AddrWidth-1:0] mem_addr,
  output logic                 mem_read,
  output logic [3:0]           mem_write,
  output logic [DataWidth-1:0] mem_di,
  input  logic [DataWidth-1:0] mem_do,

  output logic [31:0]          retired_count
);

  typedef enum logic [1:0] {
    StFetch,
    StFwait,
    StExec,
    StDwait
  } state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] instr_q, instr_d;
  logic [31:0]          retired_count_q, retired_count_d;
  logic                 commit;

  // ---------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (instr_read) begin
          state_d = StFwait;
        end
      end
      StFwait: begin
        state_d = StExec;
      end
      StExec: begin
        // A store takes priority over a load requested in the same cycle.
        if (data_write != 4'b0000) begin
          state_d = StFetch;
        end else if (data_read) begin
          state_d = StDwait;
        end else begin
          state_d = StFetch;
        end
      end
      StDwait: begin
        state_d = StFetch;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------------------
  // mem_* depends only on state and CPU inputs, never on mem_do, so there is no loop through
  // the SRAM read port. Reset overrides everything so a pending store is dropped.
  always_comb begin
    cpu_stall = 1'b1;
    mem_read  = 1'b0;
    mem_write = 4'b0000;
    mem_addr  = instr_addr;
    mem_di    = '0;
    data_out  = '0;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          mem_read = instr_read;
        end
        StFwait: begin
          // SRAM is returning the instruction word; no new access.
        end
        StExec: begin
          mem_addr = data_addr;
          if (data_write != 4'b0000) begin
            mem_write = data_write;
            mem_di    = data_in;
            cpu_stall = 1'b0;
          end else if (data_read) begin
            mem_read = 1'b1;
          end else begin
            cpu_stall = 1'b0;
          end
        end
        StDwait: begin
          data_out  = mem_do;
          cpu_stall = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------
  // Instruction hold register and retire counter
  // ---------------------------------------------------------------------------------------
  // The commit cycle is exactly the one cycle per sequence where the stall is released.
  assign commit = ~cpu_stall;

  always_comb begin
    instr_d         = instr_q;
    retired_count_d = retired_count_q;
    if (state_q == StFwait) begin
      instr_d = mem_do;
    end
    if (commit) begin
      retired_count_d = retired_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q         <= NopInstr[DataWidth-1:0];
      retired_count_q <= 32'd0;
    end else begin
      instr_q         <= instr_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign instr_out     = instr_q;
  assign retired_count = retired_count_q;

  // ---------------------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------------------
  // Never two commits back to back.
  commit_spacing_a: assert property (@(posedge clk) disable iff (rst) commit |=> !commit);

  // SRAM writes only ever come from the execute cycle.
  write_in_exec_a: assert property (@(posedge clk) disable iff (rst)
    (mem_write != 4'b0000) |-> (state_q == StExec));

  // A read and a write are never issued together.
  no_rd_wr_a: assert property (@(posedge clk) disable iff (rst)
    !(mem_read && (mem_write != 4'b0000)));

endmodule

// File: doc/sram_port_sequencer.md
# sram_port_sequencer

Multi-cycle sequencer that shares one synchronous single-port SRAM between the CPU's instruction-fetch port and its data port. It holds each fetched instruction stable, issues the data load or store that the instruction requests, and drives a stall so the single-cycle CPU commits exactly one instruction per sequence. It sits between the CPU (`instr_*`/`data_*` ports) and the SRAM (`addr`/`read`/`write`/`DI`/`DO`).

## Interface
- `AddrWidth`, 32: address width of CPU and SRAM ports.
- `DataWidth`, 32: data width.
- `NopInstr`, 32'h0000_0013: value of `instr_out` after reset (`addi x0,x0,0`).

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `instr_read`  in  1  CPU fetch request; tied high by the CPU, sampled in FETCH only.
- `instr_addr`  in  AddrWidth  CPU PC.
- `instr_out`  out  DataWidth  held instruction to the CPU.
- `data_read`  in  1  CPU load request, valid only in EXEC.
- `data_write`  in  4  CPU byte strobes, valid only in EXEC.
- `data_addr`  in  AddrWidth  load/store address.
- `data_in`  in  DataWidth  store data.
- `data_out`  out  DataWidth  load data to the CPU.
- `cpu_stall`  out  1  high = CPU must not update PC or write registers.
- `mem_addr`  out  AddrWidth  SRAM address.
- `mem_read`  out  1  SRAM read enable.
- `mem_write`  out  4  SRAM byte write strobes.
- `mem_di`  out  DataWidth  SRAM write data.
- `mem_do`  in  DataWidth  SRAM read data; valid the cycle after `mem_read` is sampled.
- `retired_count`  out  32  instructions committed since reset.

## Operation
- FSM states: FETCH, FWAIT, EXEC, DWAIT. Reset state FETCH.
- FETCH: `mem_read`=`instr_read`, `mem_addr`=`instr_addr`, `mem_write`=0. If `instr_read`=0, stay in FETCH; otherwise go to FWAIT.
- FWAIT: `mem_read`=0. `instr_q` <= `mem_do` at the end of the cycle. Next state EXEC.
- EXEC: `instr_out`=`instr_q`. The CPU decodes and drives its `data_*` signals.
  - `data_write`!=0: `mem_write`=`data_write`, `mem_addr`=`data_addr`, `mem_di`=`data_in`, `cpu_stall`=0 (commit). Next state FETCH.
  - else if `data_read`: `mem_read`=1, `mem_addr`=`data_addr`, `cpu_stall`=1. Next state DWAIT.
  - else: no SRAM access, `cpu_stall`=0 (commit). Next state FETCH.
  - `data_write`!=0 and `data_read`=1 together: the write wins and the read is dropped.
- DWAIT: `data_out`=`mem_do` combinationally, `cpu_stall`=0 (commit), no SRAM access. Next state FETCH.
- Outside EXEC, the CPU's `data_*` inputs are ignored. `mem_write` is nonzero only in EXEC.
- `instr_out` is `instr_q` in every state. It changes only at the FWAIT→EXEC edge.
- `data_out` is 0 in every state except DWAIT.
- `retired_count` increments by 1 on every commit edge and wraps from 0xFFFF_FFFF to 0.
- Reset values: state FETCH, `instr_q`=`NopInstr`, `retired_count`=0.
- While `rst`=1, outputs are forced: `cpu_stall`=1, `mem_read`=0, `mem_write`=0, `data_out`=0.
- Reset mid-sequence (any state) drops the pending access with no SRAM write. After `rst` falls, sequencing restarts with FETCH.

## Timing
- Non-memory instruction: 3 cycles (FETCH, FWAIT, EXEC). `cpu_stall` is low in EXEC only.
- Store: 3 cycles. The SRAM write occurs at the EXEC→FETCH edge, coincident with commit.
- Load: 4 cycles (FETCH, FWAIT, EXEC, DWAIT). `cpu_stall` is low in DWAIT only.
- `cpu_stall` is low for exactly one cycle per instruction and never low on two consecutive cycles.
- Combinational paths: `instr_addr`/`data_*` → `mem_*`, and `mem_do` → `data_out`. There is no path from `mem_do` to `mem_*`.

## Test plan
- Reset then release, with `instr_addr`=0x0 and SRAM[0]=0x00500093 → FETCH read at 0x0 on the first cycle after release; `instr_out`=0x00000013 until the EXEC cycle, then 0x00500093; `cpu_stall` low only in the 3rd cycle; `retired_count`=1 afterwards.
- Load: `instr_q` holds an lw; in EXEC drive `data_read`=1, `data_addr`=0x100; SRAM[0x100]=0xDEADBEEF → `mem_read`=1 with `mem_addr`=0x100 in EXEC; in DWAIT, `data_out`=0xDEADBEEF and `cpu_stall`=0; next instruction fetch starts 4 cycles after the previous one.
- Store: in EXEC drive `data_write`=4'b0011, `data_addr`=0x104, `data_in`=0x1234ABCD → `mem_write`=4'b0011 and `mem_di`=0x1234ABCD for one cycle; only the low halfword of SRAM[0x104] changes; total 3 cycles.
- Simultaneous `data_read`=1 and `data_write`=4'b1111 in EXEC → write issued, no DWAIT entered, commit in EXEC.
- `rst` asserted during EXEC with `data_write`=4'b1111 → `mem_write` stays 0 and SRAM is unchanged; `retired_count`=0; the FSM is in FETCH on the first cycle after release.
- `instr_read`=0 held for 5 cycles → FSM holds in FETCH with `cpu_stall`=1 and `mem_read`=0; preload `retired_count` to 0xFFFF_FFFF via force, commit once → it reads 0.
